// File: rtl/seg_bcd_feed_if.sv
// Display-write bus between the CPU side and the digit feeder.
// The CPU side drives the request; the feeder returns digits and the load strobe.
interface seg_bcd_feed_if;
   logic        start;
   logic [15:0] value;
   logic        hex_mode;
   logic        busy;
   logic [3:0]  l0;
   logic [3:0]  l1;
   logic [3:0]  l2;
   logic [3:0]  l3;
   logic        LEDCtrl;
   logic        ovf;

   modport master (
      output start, value, hex_mode,
      input  busy, l0, l1, l2, l3, LEDCtrl, ovf
   );

   modport slave (
      input  start, value, hex_mode,
      output busy, l0, l1, l2, l3, LEDCtrl, ovf
   );
endinterface

// File: rtl/seg_bcd_feed.sv
// Converts a 16-bit value to four digit codes (hex or double-dabble decimal)
// and strobes the seven-segment scanner once per complete digit set.
module seg_bcd_feed #(
   parameter logic [3:0] BLANK_CODE = 4'hE
) (
   input logic          clk,
   input logic          rst_n,
   seg_bcd_feed_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_sr;
   logic [15:0] r_acc;
   logic [4:0]  r_cnt;
   logic [3:0]  r_l0;
   logic [3:0]  r_l1;
   logic [3:0]  r_l2;
   logic [3:0]  r_l3;
   logic        r_ovf;
   logic        r_led;
   logic [15:0] w_adj;
   logic [31:0] w_shift;
   logic        w_last;
   logic        w_big;

   // Nibble corrections all see the pre-edge accumulator.
   always_comb begin
      w_adj = r_acc;
      for (int i = 0; i < 4; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
      w_shift = {w_adj, r_sr} << 1;
      w_last  = (r_cnt == 5'd15);
      w_big   = (bus.value > 16'd9999);
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start)
               w_next = (bus.hex_mode || w_big) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            if (w_last)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_l0    <= '0;
         r_l1    <= '0;
         r_l2    <= '0;
         r_l3    <= '0;
         r_ovf   <= 1'b0;
         r_led   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_led   <= (w_next == S_DONE);
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.hex_mode) begin
                     r_l3  <= bus.value[15:12];
                     r_l2  <= bus.value[11:8];
                     r_l1  <= bus.value[7:4];
                     r_l0  <= bus.value[3:0];
                     r_ovf <= 1'b0;
                  end else if (w_big) begin
                     r_l3  <= BLANK_CODE;
                     r_l2  <= BLANK_CODE;
                     r_l1  <= BLANK_CODE;
                     r_l0  <= BLANK_CODE;
                     r_ovf <= 1'b1;
                  end else begin
                     r_sr  <= bus.value;
                     r_acc <= '0;
                     r_cnt <= '0;
                  end
               end
            end
            S_SHIFT: begin
               r_acc <= w_shift[31:16];
               r_sr  <= w_shift[15:0];
               if (w_last) begin
                  r_l3  <= w_shift[31:28];
                  r_l2  <= w_shift[27:24];
                  r_l1  <= w_shift[23:20];
                  r_l0  <= w_shift[19:16];
                  r_ovf <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (r_state != S_IDLE);
   assign bus.LEDCtrl = r_led;
   assign bus.ovf     = r_ovf;
   assign bus.l0      = r_l0;
   assign bus.l1      = r_l1;
   assign bus.l2      = r_l2;
   assign bus.l3      = r_l3;

endmodule
